filter_sched: RTL and testbench

//  Sequencer and coefficient-memory arbiter for the 128-tap symmetric FIR filter datapath.
//  - Accepts input samples on a valid/ready handshake and issues one din_enable pulse per sample.
//  - Times the filter's MAC pass and presents the result on a valid/ready output.
//  - Owns the 64x36 coefficient RAM and shares it between host writes and filter reads.

---
 rtl/filter_pkg.sv | 18 +
 rtl/filter_sched_if.sv | 26 ++
 rtl/coeff_ram.sv | 19 +
 rtl/filter_sched.sv | 113 +++++++++++
 tb/tb_filter_sched.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared sizing constants and sequencer state encoding for the symmetric FIR filter.
package filter_pkg;
  localparam int NWINDOW  = 128;
  localparam int NCOEFF   = NWINDOW / 2;
  localparam int DW       = 16;
  localparam int CW       = 36;
  localparam int AW       = $clog2(NCOEFF);
  localparam int FILT_LAT = 67;
  localparam int CNTW     = $clog2(FILT_LAT);

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_HOLD  = 3'd4
  } state_e;
endpackage

// File: rtl/filter_sched_if.sv
// Sample in/out handshakes and host coefficient-write port of the filter sequencer.
interface filter_sched_if
  import filter_pkg::*;
();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          cfg_ready;
  logic          cfg_flush;

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata, cfg_flush,
    output in_ready, out_valid, out_data, cfg_ready
  );

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata, cfg_flush,
    input  in_ready, out_valid, out_data, cfg_ready
  );
endinterface

// File: rtl/coeff_ram.sv
// Coefficient store: one synchronous write port, one combinational read port, no reset.
module coeff_ram
  import filter_pkg::*;
(
  input  logic          clock_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [CW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [CW-1:0] rdata_o
);
  logic [CW-1:0] mem_q [NCOEFF];

  always_ff @(posedge clock_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/filter_sched.sv
// Sequencer for the FIR datapath: sample strobe, MAC-pass timing, result hold and
// arbitration of the coefficient RAM between host writes and filter reads.
//
//   state | meaning
//   FLUSH | filter history cleared (filt_reset high for one cycle)
//   IDLE  | host may write coefficients; otherwise a sample may be accepted
//   LOAD  | one-cycle din_enable strobe, latency counter loaded
//   RUN   | counting down the filter latency
//   HOLD  | result presented until downstream takes it
module filter_sched
  import filter_pkg::*;
(
  input  logic           clock_i,
  input  logic           reset_ni,
  filter_sched_if.slave  bus,
  output logic           filt_reset_o,
  output logic           filt_din_enable_o,
  output logic [DW-1:0]  filt_datain_o,
  input  logic [AW-1:0]  filt_coeffaddr_i,
  output logic [CW-1:0]  filt_coeff_o,
  input  logic [DW-1:0]  filt_dataout_i,
  output logic [15:0]    sample_count_o
);
  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   datain_q, datain_d;
  logic [DW-1:0]   odata_q, odata_d;
  logic [15:0]     count_q, count_d;
  logic            in_ready, cfg_ready, filt_reset, din_en;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_FLUSH;
      cnt_q    <= '0;
      datain_q <= '0;
      odata_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      datain_q <= datain_d;
      odata_q  <= odata_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    datain_d   = datain_q;
    odata_d    = odata_q;
    count_d    = count_q;
    in_ready   = 1'b0;
    cfg_ready  = 1'b0;
    filt_reset = 1'b0;
    din_en     = 1'b0;
    case (state_q)
      S_FLUSH: begin
        filt_reset = 1'b1;
        state_d    = S_IDLE;
      end
      S_IDLE: begin
        // A flush pre-empts both the host write and the sample, so neither is acknowledged.
        cfg_ready = ~bus.cfg_flush;
        in_ready  = ~bus.cfg_flush & ~bus.cfg_we;
        if (bus.cfg_flush) begin
          state_d = S_FLUSH;
        end else if (!bus.cfg_we && bus.in_valid) begin
          datain_d = bus.in_data;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        din_en  = 1'b1;
        cnt_d   = CNTW'(FILT_LAT - 1);
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          odata_d = filt_dataout_i;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

  coeff_ram u_coeff_ram (
    .clock_i (clock_i),
    .we_i    (bus.cfg_we & cfg_ready),
    .waddr_i (bus.cfg_addr),
    .wdata_i (bus.cfg_wdata),
    .raddr_i (filt_coeffaddr_i),
    .rdata_o (filt_coeff_o)
  );

  assign bus.in_ready      = in_ready;
  assign bus.cfg_ready     = cfg_ready;
  assign bus.out_valid     = (state_q == S_HOLD);
  assign bus.out_data      = odata_q;
  assign filt_reset_o      = filt_reset;
  assign filt_din_enable_o = din_en;
  assign filt_datain_o     = datain_q;
  assign sample_count_o    = count_q;
endmodule

// File: tb/tb_filter_sched.sv
// Randomized self-checking bench for filter_sched with a timed filter model and RAM model.
module tb_filter_sched;
  import filter_pkg::*;

  logic          clock_i  = 1'b0;
  logic          reset_ni = 1'b0;
  logic          filt_reset;
  logic          filt_din_enable;
  logic [DW-1:0] filt_datain;
  logic [DW-1:0] filt_dataout;
  logic [AW-1:0] filt_coeffaddr = '0;
  logic [CW-1:0] filt_coeff;
  logic [15:0]   sample_count;

  filter_sched_if bus ();

  filter_sched dut (
    .clock_i           (clock_i),
    .reset_ni          (reset_ni),
    .bus               (bus),
    .filt_reset_o      (filt_reset),
    .filt_din_enable_o (filt_din_enable),
    .filt_datain_o     (filt_datain),
    .filt_coeffaddr_i  (filt_coeffaddr),
    .filt_coeff_o      (filt_coeff),
    .filt_dataout_i    (filt_dataout),
    .sample_count_o    (sample_count)
  );

  always #5 clock_i = ~clock_i;

  localparam logic [DW-1:0] XMASK = 16'h1334;

  int            n_checks  = 0;
  int            n_fail    = 0;
  int            exp_count = 0;
  int            n_accept  = 0;
  int            n_pulses  = 0;
  int            age       = 1000;
  logic [DW-1:0] filt_res  = '0;
  logic [CW-1:0] ram_m [NCOEFF];

  // Filter model: the result is valid only in the cycle FILT_LAT cycles after the strobe.
  always @(posedge clock_i) begin
    if (filt_din_enable) begin
      age      <= 0;
      filt_res <= filt_datain ^ XMASK;
      n_pulses <= n_pulses + 1;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end
  assign filt_dataout = (age == FILT_LAT - 1) ? filt_res : (~filt_res ^ 16'h5A5A);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    #1;
    chk("cfg_ready_idle", bus.cfg_ready, 1'b1);
    step();
    ram_m[a]   = d;
    bus.cfg_we = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] x);
    int b = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    #1;
    while (bus.in_ready !== 1'b1 && b < 100) begin
      step();
      b++;
    end
    chk("accept_bound", 64'(b < 100), 64'd1);
    step();
    bus.in_valid = 1'b0;
    n_accept++;
    chk("din_enable", filt_din_enable, 1'b1);
    chk("filt_datain", filt_datain, x);
  endtask

  task automatic collect(input logic [DW-1:0] x, input int bp, input bit noise);
    int n = 0;
    bus.out_ready = (bp == 0);
    while (bus.out_valid !== 1'b1 && n < 200) begin
      if (noise && n < 30) begin
        bus.cfg_we     = 1'($urandom);
        bus.cfg_addr   = AW'($urandom);
        bus.cfg_wdata  = {4'($urandom), 32'($urandom)};
        bus.cfg_flush  = 1'($urandom);
        filt_coeffaddr = AW'($urandom);
        #1;
        chk("busy_cfg_ready", bus.cfg_ready, 1'b0);
        chk("busy_in_ready", bus.in_ready, 1'b0);
        chk("run_coeff", filt_coeff, ram_m[filt_coeffaddr]);
      end else begin
        bus.cfg_we    = 1'b0;
        bus.cfg_flush = 1'b0;
      end
      step();
      n++;
    end
    bus.cfg_we    = 1'b0;
    bus.cfg_flush = 1'b0;
    chk("latency", n, FILT_LAT + 1);
    chk("out_data", bus.out_data, x ^ XMASK);
    for (int i = 0; i < bp; i++) begin
      step();
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_data", bus.out_data, x ^ XMASK);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    step();
    exp_count++;
    chk("valid_drop", bus.out_valid, 1'b0);
    chk("sample_count", sample_count, exp_count);
    chk("back_idle", bus.in_ready, 1'b1);
  endtask

  task automatic reset_mid(input bit in_hold);
    int n = 0;
    int stale = 0;
    send_sample(16'($urandom));
    bus.out_ready = 1'b0;
    if (in_hold) begin
      while (bus.out_valid !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      chk("pre_reset_valid", bus.out_valid, 1'b1);
    end else begin
      repeat (20) step();
    end
    reset_ni = 1'b0;
    #1;
    exp_count = 0;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_filt_reset", filt_reset, 1'b1);
    chk("rst_count", sample_count, exp_count);
    chk("rst_out_data", bus.out_data, 16'h0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    step();
    step();
    reset_ni = 1'b1;
    step();
    chk("rel_filt_reset", filt_reset, 1'b0);
    chk("rel_in_ready", bus.in_ready, 1'b1);
    repeat (100) begin
      step();
      if (bus.out_valid !== 1'b0) stale++;
    end
    chk("stale_valid", stale, 0);
    chk("rel_count", sample_count, exp_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.cfg_flush = 1'b0;

    // Reset state and release
    #2;
    chk("r_filt_reset", filt_reset, 1'b1);
    chk("r_in_ready", bus.in_ready, 1'b0);
    chk("r_cfg_ready", bus.cfg_ready, 1'b0);
    chk("r_out_valid", bus.out_valid, 1'b0);
    chk("r_out_data", bus.out_data, 16'h0);
    chk("r_din_enable", filt_din_enable, 1'b0);
    chk("r_datain", filt_datain, 16'h0);
    chk("r_count", sample_count, 16'h0);
    step();
    step();
    reset_ni = 1'b1;
    chk("rel_pre_edge_reset", filt_reset, 1'b1);
    step();
    chk("rel_filt_reset0", filt_reset, 1'b0);
    chk("rel_cfg_ready", bus.cfg_ready, 1'b1);
    chk("rel_in_ready1", bus.in_ready, 1'b1);
    step();
    chk("no_pulse", n_pulses, 0);

    // Coefficient write and readback
    cfg_write(6'd5, 36'h0_0000_1000);
    filt_coeffaddr = 6'd5;
    #1;
    chk("coeff5", filt_coeff, 36'h0_0000_1000);
    for (int a = 0; a < NCOEFF; a++) cfg_write(AW'(a), {4'($urandom), 32'($urandom)});
    for (int k = 0; k < 8; k++) begin
      filt_coeffaddr = AW'($urandom);
      #1;
      chk("coeff_rd", filt_coeff, ram_m[filt_coeffaddr]);
    end

    // Write and sample together: write wins, sample waits one cycle
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 6'd9;
    bus.cfg_wdata = 36'h9_8765_4321;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0100;
    #1;
    chk("arb_in_ready", bus.in_ready, 1'b0);
    chk("arb_cfg_ready", bus.cfg_ready, 1'b1);
    step();
    ram_m[9]       = 36'h9_8765_4321;
    bus.cfg_we     = 1'b0;
    filt_coeffaddr = 6'd9;
    #1;
    chk("arb_written", filt_coeff, 36'h9_8765_4321);
    chk("arb_no_strobe", filt_din_enable, 1'b0);
    chk("arb_in_ready_next", bus.in_ready, 1'b1);
    send_sample(16'h0100);
    collect(16'h0100, 0, 1'b0);

    // Flush from IDLE
    bus.cfg_flush = 1'b1;
    step();
    bus.cfg_flush = 1'b0;
    chk("flush_reset", filt_reset, 1'b1);
    chk("flush_in_ready", bus.in_ready, 1'b0);
    step();
    chk("flush_done", filt_reset, 1'b0);
    chk("flush_idle", bus.in_ready, 1'b1);

    // Backpressure
    send_sample(16'hABCD);
    collect(16'hABCD, 10, 1'b0);

    // Randomized traffic with ignored writes/flushes while busy
    for (int t = 0; t < 15; t++) begin
      logic [DW-1:0] x;
      repeat ($urandom_range(0, 2)) cfg_write(AW'($urandom), {4'($urandom), 32'($urandom)});
      filt_coeffaddr = AW'($urandom);
      #1;
      chk("idle_coeff", filt_coeff, ram_m[filt_coeffaddr]);
      x = 16'($urandom);
      send_sample(x);
      collect(x, $urandom_range(0, 5), 1'b1);
    end
    chk("pulse_count", n_pulses, n_accept);

    // Reset while the result is pending, then while it is held
    reset_mid(1'b0);
    reset_mid(1'b1);
    chk("pulse_count_end", n_pulses, n_accept);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
